eject_buffer: RTL and testbench

- Sits directly downstream of the router's local-port ejector.
- Captures the winning ejected flit each cycle into a small FIFO and presents flits to the local PE/NI with a valid/ready handshake.
- Exports a registered-derived eject_ready so the router can deflect local-bound flits instead of ejecting them when the buffer is full.
- Also keeps an ejected-flit counter and a sticky overflow flag for debug and verification.

---
 rtl/eject_buffer_pkg.sv | 17 +
 rtl/eject_buffer_sync_fifo.sv | 59 +++++
 rtl/globalVariable.v | 13 +
 rtl/eject_buffer.sv | 74 +++++++
 tb/tb_eject_buffer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eject_buffer_pkg.sv
// Flit geometry and defaults for the eject buffer, derived from the shared global include.
`include "globalVariable.v"

package eject_buffer_pkg;

  localparam int FLIT_W        = `IN_ROUTER_SIZE;
  localparam int LOCAL_BIT     = `PROD_VECTOR_LOCAL;
  localparam int GOLDEN_BIT    = `GOLDEN;
  localparam int DEFAULT_DEPTH = `EJECT_BUF_DEPTH;

  typedef logic [FLIT_W-1:0] flit_t;

  function automatic logic is_local(input flit_t flit);
    return flit[LOCAL_BIT];
  endfunction

endpackage

// File: rtl/eject_buffer_sync_fifo.sv
// Generic width/depth synchronous FIFO; the head is read combinationally from storage.
module eject_buffer_sync_fifo #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [WIDTH-1:0]  data_i,
  output logic [WIDTH-1:0]  data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it holding a stale value (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    if (push_i && !pop_i)      count_d = count_q + (ADDR_W + 1)'(1);
    else if (pop_i && !push_i) count_d = count_q - (ADDR_W + 1)'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/globalVariable.v
// Shared NoC flit geometry used across the router and its local-port logic.
`ifndef GLOBAL_VARIABLE_V
`define GLOBAL_VARIABLE_V

`define IN_ROUTER_SIZE    32
`define PROD_VECTOR_LOCAL 31
`define GOLDEN            30
`define FLIT_NUM          29:26

// System-wide default depth of the local-port eject buffer.
`define EJECT_BUF_DEPTH   4

`endif

// File: rtl/eject_buffer.sv
// Local-port eject buffer: captures ejected flits into a FIFO, handshakes them to the PE,
// and exports a register-derived eject_ready plus debug counters.
module eject_buffer
  import eject_buffer_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              eject_ready,
  output logic [FLIT_W-1:0] pe_flit,
  output logic              pe_valid,
  input  logic              pe_ready,
  output logic [CNT_W-1:0]  eject_count,
  output logic              overflow
);

  logic            flit_valid;
  logic            push, pop, drop;
  logic            fifo_full, fifo_empty;
  logic [ADDR_W:0] fifo_count;

  logic [CNT_W-1:0] eject_count_q, eject_count_d;
  logic             overflow_q, overflow_d;

  assign flit_valid = is_local(in_flit);
  assign pop        = pe_valid & pe_ready;
  // A full buffer still accepts a flit when the head leaves in the same cycle.
  assign push       = flit_valid & (~fifo_full | pop);
  assign drop       = flit_valid & fifo_full & ~pop;

  eject_buffer_sync_fifo #(
    .WIDTH  (FLIT_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (in_flit),
    .data_o  (pe_flit),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    eject_count_d = eject_count_q;
    overflow_d    = overflow_q;
    if (push) eject_count_d = eject_count_q + CNT_W'(1);
    if (drop) overflow_d    = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eject_count_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      eject_count_q <= eject_count_d;
      overflow_q    <= overflow_d;
    end
  end

  // Full is decoded from the registered count only, so eject_ready has no input-to-output path.
  assign eject_ready = ~fifo_full;
  assign pe_valid    = ~fifo_empty;
  assign eject_count = eject_count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_eject_buffer.sv
// Directed self-checking bench for eject_buffer: one task per scenario, expected values hand-derived.
module tb_eject_buffer;
  import eject_buffer_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [FLIT_W-1:0] in_flit;
  logic              eject_ready;
  logic [FLIT_W-1:0] pe_flit;
  logic              pe_valid;
  logic              pe_ready;
  logic [15:0]       eject_count;
  logic              overflow;

  int n_vec = 0;
  int n_err = 0;

  eject_buffer #(.DEPTH(4), .ADDR_W(2), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_flit     (in_flit),
    .eject_ready (eject_ready),
    .pe_flit     (pe_flit),
    .pe_valid    (pe_valid),
    .pe_ready    (pe_ready),
    .eject_count (eject_count),
    .overflow    (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Distinct valid flit per id; golden bit and flit-number field vary with id.
  function automatic flit_t mk(input int id);
    flit_t f;
    f = flit_t'(id * 32'h0013_5A7B ^ 32'h2468_ACE0);
    f[LOCAL_BIT]  = 1'b1;
    f[GOLDEN_BIT] = id[0];
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_flit  = '0;
    pe_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if ({pe_valid, eject_ready, overflow, eject_count} !== {1'b0, 1'b1, 1'b0, 16'h0}) begin
      n_err++;
      $display("FAIL reset_state got v=%b rdy=%b ovf=%b cnt=%0d exp v=0 rdy=1 ovf=0 cnt=0",
               pe_valid, eject_ready, overflow, eject_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    in_flit = 32'h7FFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if ({pe_valid, eject_ready, overflow, eject_count} !== {1'b0, 1'b1, 1'b0, 16'h0}) begin
        n_err++;
        $display("FAIL idle[%0d] got v=%b rdy=%b ovf=%b cnt=%0d exp v=0 rdy=1 ovf=0 cnt=0",
                 i, pe_valid, eject_ready, overflow, eject_count);
      end
    end
    in_flit = '0;
  endtask

  task automatic test_single();
    do_reset();
    pe_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    in_flit = mk(1);
    step();
    n_vec++;
    if ({pe_valid, pe_flit, eject_count} !== {1'b1, mk(1), 16'd1}) begin
      n_err++;
      $display("FAIL single_head got v=%b flit=%h cnt=%0d exp v=1 flit=%h cnt=1",
               pe_valid, pe_flit, eject_count, mk(1));
    end
    in_flit = '0;
    step();
    n_vec++;
    if ({pe_valid, eject_count} !== {1'b0, 16'd1}) begin
      n_err++;
      $display("FAIL single_after got v=%b cnt=%0d exp v=0 cnt=1", pe_valid, eject_count);
    end
  endtask

  task automatic test_fill_drop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_flit = mk(i);
      step();
      n_vec++;
      if (eject_ready !== (i < 3)) begin
        n_err++;
        $display("FAIL fill_ready[%0d] got %b exp %b", i, eject_ready, (i < 3));
      end
    end
    in_flit = mk(4);
    step();
    n_vec++;
    if ({overflow, eject_count, eject_ready, pe_flit} !== {1'b1, 16'd4, 1'b0, mk(0)}) begin
      n_err++;
      $display("FAIL drop got ovf=%b cnt=%0d rdy=%b head=%h exp ovf=1 cnt=4 rdy=0 head=%h",
               overflow, eject_count, eject_ready, pe_flit, mk(0));
    end
    in_flit  = '0;
    pe_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({pe_valid, pe_flit} !== {1'b1, mk(i)}) begin
        n_err++;
        $display("FAIL drain_order[%0d] got v=%b flit=%h exp v=1 flit=%h", i, pe_valid, pe_flit, mk(i));
      end
      step();
      n_vec++;
      if (eject_ready !== 1'b1) begin
        n_err++;
        $display("FAIL drain_ready[%0d] got %b exp 1", i, eject_ready);
      end
    end
    n_vec++;
    if ({pe_valid, overflow} !== 2'b01) begin
      n_err++;
      $display("FAIL drain_end got v=%b ovf=%b exp v=0 ovf=1", pe_valid, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 10; i < 14; i++) begin
      in_flit = mk(i);
      step();
    end
    pe_ready = 1'b1;
    in_flit  = mk(14);
    step();
    n_vec++;
    if ({eject_ready, overflow, eject_count, pe_flit} !== {1'b0, 1'b0, 16'd5, mk(11)}) begin
      n_err++;
      $display("FAIL full_pushpop got rdy=%b ovf=%b cnt=%0d head=%h exp rdy=0 ovf=0 cnt=5 head=%h",
               eject_ready, overflow, eject_count, pe_flit, mk(11));
    end
    in_flit = '0;
    for (int i = 11; i < 15; i++) begin
      n_vec++;
      if ({pe_valid, pe_flit} !== {1'b1, mk(i)}) begin
        n_err++;
        $display("FAIL full_order[%0d] got v=%b flit=%h exp v=1 flit=%h", i, pe_valid, pe_flit, mk(i));
      end
      step();
    end
    n_vec++;
    if (pe_valid !== 1'b0) begin
      n_err++;
      $display("FAIL full_empty got v=%b exp 0", pe_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    pe_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_flit = mk(20 + i);
      step();
      n_vec++;
      if ({pe_valid, pe_flit, eject_ready} !== {1'b1, mk(20 + i), 1'b1}) begin
        n_err++;
        $display("FAIL stream[%0d] got v=%b flit=%h rdy=%b exp v=1 flit=%h rdy=1",
                 i, pe_valid, pe_flit, eject_ready, mk(20 + i));
      end
    end
    in_flit = '0;
    step();
    n_vec++;
    if ({pe_valid, eject_count} !== {1'b0, 16'd20}) begin
      n_err++;
      $display("FAIL stream_end got v=%b cnt=%0d exp v=0 cnt=20", pe_valid, eject_count);
    end
  endtask

  task automatic test_count_wrap();
    do_reset();
    pe_ready = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      in_flit = mk(i & 255);
      step();
    end
    n_vec++;
    if (eject_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL wrap_pre got cnt=%h exp ffff", eject_count);
    end
    in_flit = mk(77);
    step();
    n_vec++;
    if ({eject_count, pe_flit} !== {16'h0000, mk(77)}) begin
      n_err++;
      $display("FAIL wrap_post got cnt=%h flit=%h exp cnt=0000 flit=%h", eject_count, pe_flit, mk(77));
    end
    in_flit = '0;
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 40; i < 45; i++) begin
      in_flit = mk(i);
      step();
    end
    in_flit  = '0;
    pe_ready = 1'b1;
    step();
    pe_ready = 1'b0;
    n_vec++;
    if ({pe_valid, overflow, eject_ready, pe_flit} !== {1'b1, 1'b1, 1'b1, mk(41)}) begin
      n_err++;
      $display("FAIL arst_pre got v=%b ovf=%b rdy=%b head=%h exp v=1 ovf=1 rdy=1 head=%h",
               pe_valid, overflow, eject_ready, pe_flit, mk(41));
    end
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({pe_valid, eject_ready, overflow, eject_count} !== {1'b0, 1'b1, 1'b0, 16'h0}) begin
      n_err++;
      $display("FAIL arst_now got v=%b rdy=%b ovf=%b cnt=%0d exp v=0 rdy=1 ovf=0 cnt=0",
               pe_valid, eject_ready, overflow, eject_count);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    pe_ready = 1'b1;
    in_flit  = mk(50);
    step();
    n_vec++;
    if ({pe_valid, pe_flit, eject_count} !== {1'b1, mk(50), 16'd1}) begin
      n_err++;
      $display("FAIL arst_fresh got v=%b flit=%h cnt=%0d exp v=1 flit=%h cnt=1",
               pe_valid, pe_flit, eject_count, mk(50));
    end
    in_flit = '0;
    step();
    n_vec++;
    if (pe_valid !== 1'b0) begin
      n_err++;
      $display("FAIL arst_drain got v=%b exp 0", pe_valid);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_flit  = '0;
    pe_ready = 1'b0;
    test_reset();
    test_idle();
    test_single();
    test_fill_drop();
    test_full_push_pop();
    test_back_to_back();
    test_count_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
